// File: rtl/i2s_pkg.sv
// Shared I2S framing constants and the BCLK edge event type used by both the
// transmit and receive control paths.
package i2s_pkg;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;

    typedef enum logic [1:0] {
        BCLK_IDLE = 2'b00,
        BCLK_RISE = 2'b01,
        BCLK_FALL = 2'b10
    } bclkEvent_e;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Divides the system clock down to BCLK and flags the system-clock cycle in
// which each BCLK edge happens, so downstream logic stays in the clk domain.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       bclk,
    output bclkEvent_e evt
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] divCnt;
    logic             wrap;

    assign wrap = (divCnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            divCnt <= '0;
            bclk   <= 1'b0;
        end else if (wrap) begin
            divCnt <= '0;
            bclk   <= ~bclk;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    // The event describes the toggle committed at the coming clk edge.
    always_comb begin
        evt = BCLK_IDLE;
        if (wrap) begin
            evt = bclk ? BCLK_FALL : BCLK_RISE;
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// Master-mode I2S serializer: one holding register behind a valid/ready port,
// 64-bit frames of two 32-bit slots, data delayed one BCLK after each LRCLK edge.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_left,
    input  logic [DATA_WIDTH-1:0] in_right,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  BCLK,
    output logic                  LRCLK,
    output logic                  SDATA,
    output logic                  NewFrame,
    output logic                  underrun
);

    bclkEvent_e            evt;
    logic                  fe;
    logic                  load;
    logic                  accept;
    logic [5:0]            frameBit;
    logic [5:0]            nextBit;
    logic [4:0]            bitCount;
    logic                  holdFull;
    logic [DATA_WIDTH-1:0] holdLeft;
    logic [DATA_WIDTH-1:0] holdRight;
    logic [DATA_WIDTH-1:0] leftWord;
    logic [DATA_WIDTH-1:0] rightWord;
    logic [SLOT_BITS-1:0]  slotWord;
    logic                  sdataNext;

    i2s_bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_gen (
        .clk   (clk),
        .reset (reset),
        .bclk  (BCLK),
        .evt   (evt)
    );

    assign fe       = (evt == BCLK_FALL);
    assign load     = fe && (frameBit == 6'(FRAME_BITS - 1));
    assign accept   = in_valid && !holdFull;
    assign nextBit  = frameBit + 6'd1;
    assign bitCount = nextBit[4:0];
    assign LRCLK    = frameBit[5];
    assign in_ready = !holdFull;

    // Left-justify the word below a zero bit 31 so slot bit n maps to slotWord[31-n];
    // positions 0 and beyond DATA_WIDTH then fall on zeros without extra compares.
    always_comb begin
        slotWord  = (nextBit[5] ? SLOT_BITS'(rightWord) : SLOT_BITS'(leftWord))
                    << (SLOT_BITS - 1 - DATA_WIDTH);
        sdataNext = slotWord[5'(SLOT_BITS - 1) - bitCount];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frameBit  <= 6'(FRAME_BITS - 1);
            holdFull  <= 1'b0;
            holdLeft  <= '0;
            holdRight <= '0;
            leftWord  <= '0;
            rightWord <= '0;
            SDATA     <= 1'b0;
            NewFrame  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            NewFrame <= 1'b0;
            underrun <= 1'b0;

            if (fe) begin
                frameBit <= nextBit;
                SDATA    <= sdataNext;
            end

            if (load) begin
                NewFrame <= 1'b1;
                if (holdFull) begin
                    leftWord  <= holdLeft;
                    rightWord <= holdRight;
                    holdFull  <= 1'b0;
                end else begin
                    leftWord  <= '0;
                    rightWord <= '0;
                    underrun  <= 1'b1;
                end
            end

            // A pair accepted in the load clk lands here and waits for the next frame.
            if (accept) begin
                holdLeft  <= in_left;
                holdRight <= in_right;
                holdFull  <= 1'b1;
            end
        end
    end

endmodule
